// File: rtl/tcm_port_arbiter_if.sv
// Bus bundle between the two TCM masters, the arbiter and the TCM array.
// The arbiter takes the slave modport; the masters/TCM side takes the master modport.
interface tcm_port_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   // Handshake: a master raises mX_req with we/addr/wdata stable and holds them until
   // mX_gnt is seen high; the access happens in the cycle where req and gnt are both 1.
   // A read returns mX_rvalid/mX_rdata exactly one cycle after its grant cycle.
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [DW-1:0] m1_rdata;

   logic [AW-1:0] mem_WADDR;
   logic [DW-1:0] mem_WDATA;
   logic          mem_WEN;
   logic [AW-1:0] mem_RADDR;
   logic          mem_REN;
   logic [DW-1:0] mem_RDATA;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_RDATA,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_WADDR, mem_WDATA, mem_WEN, mem_RADDR, mem_REN
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_RDATA,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_WADDR, mem_WDATA, mem_WEN, mem_RADDR, mem_REN
   );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Two-master arbiter for a single-ported TCM with registered (1-cycle) read data.
// Bounded round-robin: an owner keeps the port for at most MAX_HOLD grants under contention.
module tcm_port_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   tcm_port_arbiter_if.slave    bus,
   output logic [1:0]           owner
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    rsel_q, rsel_d;

   logic          gnt0, gnt1;
   logic [HW-1:0] hold_inc;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;
   logic          wen, ren;

   assign hold_inc = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_ONE;

   // Grants are held off entirely while rst is high so nothing reaches the array.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (bus.m0_req && !bus.m1_req) begin
            gnt0 = 1'b1;
         end else if (!bus.m0_req && bus.m1_req) begin
            gnt1 = 1'b1;
         end else if (bus.m0_req && bus.m1_req) begin
            case (state_q)
               OWN0: begin
                  if (hold_q < HOLD_MAX) gnt0 = 1'b1;
                  else                   gnt1 = 1'b1;
               end
               OWN1: begin
                  if (hold_q < HOLD_MAX) gnt1 = 1'b1;
                  else                   gnt0 = 1'b1;
               end
               default: gnt0 = 1'b1;
            endcase
         end
      end
   end

   always_comb begin
      state_d = IDLE;
      hold_d  = '0;
      if (gnt0) begin
         state_d = OWN0;
         hold_d  = (state_q == OWN0) ? hold_inc : HOLD_ONE;
      end else if (gnt1) begin
         state_d = OWN1;
         hold_d  = (state_q == OWN1) ? hold_inc : HOLD_ONE;
      end
      rsel_d = {gnt1 & ~bus.m1_we, gnt0 & ~bus.m0_we};
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      wen       = 1'b0;
      ren       = 1'b0;
      if (gnt0) begin
         addr_sel  = bus.m0_addr;
         wdata_sel = bus.m0_wdata;
         wen       = bus.m0_we;
         ren       = ~bus.m0_we;
      end else if (gnt1) begin
         addr_sel  = bus.m1_addr;
         wdata_sel = bus.m1_wdata;
         wen       = bus.m1_we;
         ren       = ~bus.m1_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         rsel_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         rsel_q  <= rsel_d;
      end
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.mem_WADDR = addr_sel;
   assign bus.mem_RADDR = addr_sel;
   assign bus.mem_WDATA = wdata_sel;
   assign bus.mem_WEN   = wen;
   assign bus.mem_REN   = ren;

   // A read in flight when rst rises is dropped: rvalid is masked for the rst cycle itself.
   assign bus.m0_rvalid = rsel_q[0] & ~rst;
   assign bus.m1_rvalid = rsel_q[1] & ~rst;
   assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_RDATA : '0;
   assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_RDATA : '0;

   assign owner = state_q;

endmodule
